// File: rtl/char_console_writer_pkg.sv
// Shared types and constants for the character console writer: geometry, FSM state codes, default control bytes.
// Also holds the {row,col} address helper used by the writer.
package char_console_writer_pkg;

    localparam int COLS    = 32;
    localparam int ROWS    = 32;
    localparam int ADDR_W  = 10;
    localparam int COORD_W = 5;

    localparam logic [7:0] DEF_BLANK_CHAR   = 8'h00;
    localparam logic [7:0] DEF_NEWLINE_CODE = 8'h0A;
    localparam logic [7:0] DEF_CLEAR_CODE   = 8'h0C;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_PUT          = 3'd1;
    localparam state_t ST_CLEAR        = 3'd2;
    localparam state_t ST_SCROLL_RD    = 3'd3;
    localparam state_t ST_SCROLL_CAP   = 3'd4;
    localparam state_t ST_SCROLL_WR    = 3'd5;
    localparam state_t ST_SCROLL_BLANK = 3'd6;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/char_console_writer_if.sv
// Character stream plus character-RAM port bundle between a producer/display side (master) and the writer (slave).
// Pure wiring: no latency, no storage.
interface char_console_writer_if;
    import char_console_writer_pkg::*;

    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;
    logic              wr_grant;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_dout;

    modport master (
        output char_valid, char_data, wr_grant, ram_dout,
        input  char_ready, ram_addr, ram_din, ram_we
    );

    modport slave (
        input  char_valid, char_data, wr_grant, ram_dout,
        output char_ready, ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/console_cursor.sv
// Cursor row/col counters with advance, newline and home; flags when a row step would leave the last row.
// Updates on the edge its command is asserted; no backpressure. CONSOLE_SCROLL_EN pins the row at the bottom instead of wrapping.
module console_cursor
    import char_console_writer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               newline,
    input  logic               home,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               nl_wraps,
    output logic               adv_wraps
);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(ROWS - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
`ifdef CONSOLE_SCROLL_EN
    localparam logic [COORD_W-1:0] WRAP_ROW = LAST_ROW;
`else
    localparam logic [COORD_W-1:0] WRAP_ROW = '0;
`endif

    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic               row_step;

    assign row       = row_q;
    assign col       = col_q;
    assign nl_wraps  = (row_q == LAST_ROW);
    assign adv_wraps = nl_wraps && (col_q == LAST_COL);

    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        row_step = newline || (advance && (col_q == LAST_COL));
        if (home) begin
            row_d = '0;
            col_d = '0;
        end else if (advance || newline) begin
            col_d = row_step ? '0 : col_q + ONE;
            if (row_step) begin
                row_d = (row_q == LAST_ROW) ? WRAP_ROW : row_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/char_console_writer.sv
// Writes a byte stream into a 32x32 character RAM: printables, newline, clear; CONSOLE_SCROLL_EN adds scroll-up.
// Latency: accept->ram_we one cycle with grant. Backpressure: char_ready only when idle; RAM accesses stall while wr_grant is low.
module char_console_writer
    import char_console_writer_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR   = DEF_BLANK_CHAR,
    parameter logic [7:0] NEWLINE_CODE = DEF_NEWLINE_CODE,
    parameter logic [7:0] CLEAR_CODE   = DEF_CLEAR_CODE
) (
    input  logic                clk,
    input  logic                reset,
    char_console_writer_if.slave bus,
    output logic [COORD_W-1:0]  cursor_row,
    output logic [COORD_W-1:0]  cursor_col,
    output logic                busy
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              cur_adv, cur_nl, cur_home, nl_wraps, adv_wraps;
    logic              grant;

    console_cursor u_cursor (
        .clk      (clk),
        .reset    (reset),
        .advance  (cur_adv),
        .newline  (cur_nl),
        .home     (cur_home),
        .row      (cursor_row),
        .col      (cursor_col),
        .nl_wraps (nl_wraps),
        .adv_wraps(adv_wraps)
    );

    assign grant          = bus.wr_grant;
    assign bus.char_ready = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign bus.ram_addr   = addr_q;
    assign bus.ram_we     = grant && ((state_q == ST_PUT) || (state_q == ST_CLEAR) ||
                                      (state_q == ST_SCROLL_WR) || (state_q == ST_SCROLL_BLANK));

`ifdef CONSOLE_SCROLL_EN
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_DST = LAST_ADDR - ROW_STEP;
    logic [7:0] hold_q, hold_d;

    assign bus.ram_din = (state_q == ST_SCROLL_WR) ? hold_q : din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`else
    logic unused_scroll;
    assign unused_scroll = &{1'b0, nl_wraps, adv_wraps, bus.ram_dout};
    assign bus.ram_din   = din_q;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        cur_adv  = 1'b0;
        cur_nl   = 1'b0;
        cur_home = 1'b0;
`ifdef CONSOLE_SCROLL_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            ST_IDLE: if (bus.char_valid) begin
                if (bus.char_data == CLEAR_CODE) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                    din_d   = BLANK_CHAR;
                end else if (bus.char_data == NEWLINE_CODE) begin
                    cur_nl = 1'b1;
`ifdef CONSOLE_SCROLL_EN
                    if (nl_wraps) begin
                        state_d = ST_SCROLL_RD;
                        addr_d  = ROW_STEP;
                    end
`endif
                end else begin
                    state_d = ST_PUT;
                    addr_d  = cell_addr(cursor_row, cursor_col);
                    din_d   = bus.char_data;
                end
            end
            ST_PUT: if (grant) begin
                cur_adv = 1'b1;
                state_d = ST_IDLE;
`ifdef CONSOLE_SCROLL_EN
                if (adv_wraps) begin
                    state_d = ST_SCROLL_RD;
                    addr_d  = ROW_STEP;
                end
`endif
            end
            ST_CLEAR: if (grant) begin
                if (addr_q == LAST_ADDR) begin
                    cur_home = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
`ifdef CONSOLE_SCROLL_EN
            // The read address is swapped for its destination one row up while the RAM returns the byte.
            ST_SCROLL_RD: if (grant) begin
                addr_d  = addr_q - ROW_STEP;
                state_d = ST_SCROLL_CAP;
            end
            ST_SCROLL_CAP: begin
                hold_d  = bus.ram_dout;
                state_d = ST_SCROLL_WR;
            end
            ST_SCROLL_WR: if (grant) begin
                if (addr_q == LAST_DST) begin
                    addr_d  = LAST_DST + 1'b1;
                    din_d   = BLANK_CHAR;
                    state_d = ST_SCROLL_BLANK;
                end else begin
                    addr_d  = addr_q + ROW_STEP + 1'b1;
                    state_d = ST_SCROLL_RD;
                end
            end
            ST_SCROLL_BLANK: if (grant) begin
                if (addr_q == LAST_ADDR) state_d = ST_IDLE;
                else                     addr_d  = addr_q + 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_char_console_writer.sv
// Bench for char_console_writer: synchronous RAM model, screen/cursor reference model, write scoreboard.
// Random grant and random text; directed clear, newline, bottom-right wrap and reset-during-clear cases.
module tb_char_console_writer;

    localparam logic [7:0] BLANK = 8'h00;
    localparam logic [7:0] NL    = 8'h0A;
    localparam logic [7:0] CLR   = 8'h0C;
    localparam int         BUDGET = 20000;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] cursor_row, cursor_col;
    logic       busy;

    char_console_writer_if bus ();

    char_console_writer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem   [1024];
    logic [7:0]  scr   [1024];
    logic [7:0]  saved [1024];
    logic [17:0] expq  [$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, accept_cyc = 0, first_lat = -1;
    int n_writes = 0, last_addr = -1;
    int mrow = 0, mcol = 0;
    bit grant_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin : ram
        logic [7:0] rd;
        rd = mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
        bus.ram_dout <= rd;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.wr_grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.wr_grant = grant_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: every RAM write must be granted, inside a busy state, and the next expected one.
    always @(negedge clk) begin : mon
        logic [17:0] e;
        chk("ready_vs_busy", bus.char_ready, !busy);
        if (bus.ram_we) begin
            n_writes++;
            last_addr = bus.ram_addr;
            if (first_lat < 0) first_lat = cyc - accept_cyc + 1;
            chk("write_granted", bus.wr_grant, 1);
            chk("write_while_busy", busy, 1);
            if (expq.size() == 0) begin
                chk("unexpected_write", {bus.ram_addr, bus.ram_din}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("write_addr_data", {bus.ram_addr, bus.ram_din}, e);
            end
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        expq.push_back({10'(a), d});
        scr[a] = d;
    endtask

    task automatic row_advance();
        if (mrow < 31) begin
            mrow++;
        end else begin
`ifdef CONSOLE_SCROLL_EN
            for (int s = 32; s < 1024; s++) push_wr(s - 32, scr[s]);
            for (int a = 992; a < 1024; a++) push_wr(a, BLANK);
            mrow = 31;
`else
            mrow = 0;
`endif
        end
    endtask

    task automatic model_accept(input logic [7:0] c);
        if (c == CLR) begin
            for (int a = 0; a < 1024; a++) push_wr(a, BLANK);
            mrow = 0;
            mcol = 0;
        end else if (c == NL) begin
            mcol = 0;
            row_advance();
        end else begin
            push_wr(mrow * 32 + mcol, c);
            if (mcol == 31) begin
                mcol = 0;
                row_advance();
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic accept_char(input logic [7:0] c);
        int t = 0;
        @(negedge clk);
        while (!bus.char_ready && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", t < BUDGET, 1);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        first_lat  = -1;
        model_accept(c);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || expq.size() != 0) && t < BUDGET);
        chk("idle_timeout", t < BUDGET, 1);
        chk("cursor_row", cursor_row, mrow);
        chk("cursor_col", cursor_col, mcol);
    endtask

    task automatic send(input logic [7:0] c);
        accept_char(c);
        wait_idle();
    endtask

    function automatic logic [7:0] printable();
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        if (c == NL || c == CLR) c = 8'h41;
        return c;
    endfunction

    initial begin
        int w0, bad, t;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            scr[i] = mem[i];
        end
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_din", bus.ram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cursor", {cursor_row, cursor_col}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_char_ready", bus.char_ready, 1);

        send(8'h41);
        chk("a_latency", first_lat, 1);
        chk("a_addr", last_addr, 0);
        chk("a_ram", mem[0], 8'h41);
        chk("a_cursor", {cursor_row, cursor_col}, {5'd0, 5'd1});

        grant_rand = 1'b1;
        w0 = n_writes;
        send(CLR);
        chk("clr_count", n_writes - w0, 1024);
        chk("clr_last_addr", last_addr, 1023);
        chk("clr_cursor", {cursor_row, cursor_col}, 0);

        for (int i = 0; i < 33; i++) send(printable());
        chk("p33_addr", last_addr, 32);
        chk("p33_cursor", {cursor_row, cursor_col}, {5'd1, 5'd1});

        repeat (4) send(NL);
        repeat (7) send(printable());
        chk("pos_5_7", {cursor_row, cursor_col}, {5'd5, 5'd7});
        w0 = n_writes;
        send(NL);
        chk("nl_no_write", n_writes - w0, 0);
        chk("nl_cursor", {cursor_row, cursor_col}, {5'd6, 5'd0});

        for (int i = 0; i < 160; i++) send(($urandom_range(0, 99) < 22) ? NL : printable());

        while (!(mrow == 31 && mcol == 0)) send(NL);
        repeat (31) send(printable());
        chk("pos_31_31", {cursor_row, cursor_col}, {5'd31, 5'd31});
        send(8'h5A);
`ifdef CONSOLE_SCROLL_EN
        chk("z_cursor", {cursor_row, cursor_col}, {5'd31, 5'd0});
        chk("z_at_991", mem[991], 8'h5A);
        bad = 0;
        for (int a = 992; a < 1024; a++) if (mem[a] !== BLANK) bad++;
        chk("z_row31_blank", bad, 0);
`else
        chk("z_cursor", {cursor_row, cursor_col}, 0);
        chk("z_at_1023", mem[1023], 8'h5A);
`endif

        grant_rand = 1'b0;
        for (int i = 0; i < 1024; i++) saved[i] = scr[i];
        accept_char(CLR);
        t = 0;
        while (!(bus.ram_we && bus.ram_addr == 10'd500) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("clr_reach_500", t < 5000, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_ram_we", bus.ram_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", bus.char_ready, 1);
        chk("abort_cursor", {cursor_row, cursor_col}, 0);
        expq.delete();
        mrow = 0;
        mcol = 0;
        for (int i = 500; i < 1024; i++) scr[i] = saved[i];
        repeat (3) @(negedge clk);
        bad = 0;
        for (int a = 500; a < 1024; a++) if (mem[a] !== saved[a]) bad++;
        chk("abort_untouched", bad, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_abort_idle", busy, 0);

        bad = 0;
        for (int a = 0; a < 1024; a++) if (mem[a] !== scr[a]) bad++;
        chk("ram_image", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
